// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and timing constants for the LED pattern stage.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L,
    MODE_ROT_R,
    MODE_BOUNCE,
    MODE_BLINK
  } led_mode_e;

  localparam int CLK_FREQ_HZ = 100_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, stability counter and registered rising-edge press pulse.
module btn_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1_q, sync2_q;
  logic level_q, level_d;
  logic press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic accept;
  // The counter only runs while the synchronized input disagrees with the accepted level.
  always_comb begin
    accept = (sync2_q != level_q) && (cnt_q == CNT_MAX);
    cnt_d = (sync2_q == level_q || accept) ? '0 : cnt_q + CW'(1);
    level_d = accept ? sync2_q : level_q;
    press_d = level_d & ~level_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q <= cnt_d;
    end
  end
  assign level_o = level_q;
  assign press_o = press_q;
endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: button-selected mode FSM advancing a per-mode LED pattern on each tick strobe.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_i,
  input  logic                btn_i,
  output logic [NUM_LEDS-1:0] led_o,
  output logic [1:0]          mode_o
);
  localparam logic [NUM_LEDS-1:0] LSB_ONLY = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] MSB_ONLY = {1'b1, {(NUM_LEDS-1){1'b0}}};
  logic btn_level, btn_press, press;
  led_mode_e mode_q, mode_d, next_mode;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic dir_r_q, dir_r_d;

  function automatic logic [NUM_LEDS-1:0] init_pattern(input led_mode_e m);
    return (m == MODE_ROT_R) ? MSB_ONLY : (m == MODE_BLINK) ? '0 : LSB_ONLY;
  endfunction

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_i),
    .level_o(btn_level),
    .press_o(btn_press)
  );

  // A press always coincides with a high debounced level; qualifying keeps the two consistent.
  assign press = btn_press & btn_level;
  assign next_mode = led_mode_e'(mode_q + 2'd1);

  // Press has priority, so a tick in the same cycle is dropped.
  always_comb begin
    mode_d = mode_q;
    led_d = led_q;
    dir_r_d = dir_r_q;
    if (press) begin
      mode_d = next_mode;
      led_d = init_pattern(next_mode);
      dir_r_d = 1'b0;
    end else if (tick_i) begin
      unique case (mode_q)
        MODE_ROT_L: led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
        MODE_ROT_R: led_d = {led_q[0], led_q[NUM_LEDS-1:1]};
        MODE_BOUNCE: begin
          led_d = dir_r_q ? led_q >> 1 : led_q << 1;
          dir_r_d = dir_r_q ? ~led_d[0] : led_d[NUM_LEDS-1];
        end
        default: led_d = ~led_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_ROT_L;
      led_q <= LSB_ONLY;
      dir_r_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q <= led_d;
      dir_r_q <= dir_r_d;
    end
  end

  assign led_o = led_q;
  assign mode_o = mode_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed scenario tasks with hand-computed LED and mode expectations.
module tb_led_pattern_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_i = 1'b0;
  logic btn_i = 1'b0;
  logic [3:0] led_o;
  logic [1:0] mode_o;
  int total = 0;
  int bad = 0;

  led_pattern_seq #(
    .NUM_LEDS(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick_i(tick_i),
    .btn_i (btn_i),
    .led_o (led_o),
    .mode_o(mode_o)
  );

  always #5 clk = ~clk;

  task automatic tick_once;
    @(negedge clk) tick_i = 1'b1;
    @(negedge clk) tick_i = 1'b0;
  endtask

  task automatic hold_button(input int hi, input int lo);
    btn_i = 1'b1;
    repeat (hi) @(negedge clk);
    btn_i = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (led_o !== 4'b0001) begin bad++; $display("FAIL reset_led got=%b want=0001", led_o); end
    total++; if (mode_o !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rot_left;
    logic [3:0] exp [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int i = 0; i < 5; i++) begin
      tick_once();
      total++; if (led_o !== exp[i] || mode_o !== 2'd0) begin
        bad++; $display("FAIL rot_l[%0d] got=%b/%0d want=%b/0", i, led_o, mode_o, exp[i]);
      end
    end
  endtask

  task automatic test_press_latency;
    int lat = 0;
    logic [3:0] led_at = '0;
    btn_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat == 0 && mode_o !== 2'd0) begin lat = i; led_at = led_o; end
    end
    btn_i = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (lat < 11 || lat > 12) begin bad++; $display("FAIL press_latency got=%0d want=11..12", lat); end
    total++; if (led_at !== 4'b1000) begin bad++; $display("FAIL press_led got=%b want=1000", led_at); end
    total++; if (mode_o !== 2'd1) begin bad++; $display("FAIL press_single got=%0d want=1", mode_o); end
    tick_once();
    total++; if (led_o !== 4'b0100) begin bad++; $display("FAIL rot_r0 got=%b want=0100", led_o); end
    tick_once();
    total++; if (led_o !== 4'b0010) begin bad++; $display("FAIL rot_r1 got=%b want=0010", led_o); end
  endtask

  task automatic test_glitch;
    repeat (3) hold_button(5, 5);
    repeat (10) @(negedge clk);
    total++; if (mode_o !== 2'd1 || led_o !== 4'b0010) begin
      bad++; $display("FAIL glitch_ignored got=%0d/%b want=1/0010", mode_o, led_o);
    end
    hold_button(20, 20);
    total++; if (mode_o !== 2'd2 || led_o !== 4'b0001) begin
      bad++; $display("FAIL glitch_then_press got=%0d/%b want=2/0001", mode_o, led_o);
    end
  endtask

  task automatic test_bounce;
    logic [3:0] exp [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    for (int i = 0; i < 8; i++) begin
      tick_once();
      total++; if (led_o !== exp[i]) begin bad++; $display("FAIL bounce[%0d] got=%b want=%b", i, led_o, exp[i]); end
    end
  endtask

  task automatic test_blink;
    logic [3:0] exp [3] = '{4'b1111, 4'b0000, 4'b1111};
    hold_button(20, 20);
    total++; if (mode_o !== 2'd3 || led_o !== 4'b0000) begin
      bad++; $display("FAIL blink_enter got=%0d/%b want=3/0000", mode_o, led_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick_once();
      total++; if (led_o !== exp[i]) begin bad++; $display("FAIL blink[%0d] got=%b want=%b", i, led_o, exp[i]); end
    end
    hold_button(20, 20);
    total++; if (mode_o !== 2'd0 || led_o !== 4'b0001) begin
      bad++; $display("FAIL wrap_to_rot_l got=%0d/%b want=0/0001", mode_o, led_o);
    end
  endtask

  task automatic test_coincident;
    bit seen = 1'b0;
    btn_i = 1'b1;
    tick_i = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mode_o !== 2'd0) seen = 1'b1;
    end
    tick_i = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL coincident_timeout got=mode%0d want=mode1", mode_o); end
    total++; if (led_o !== 4'b1000) begin bad++; $display("FAIL coincident_led got=%b want=1000", led_o); end
    btn_i = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (mode_o !== 2'd1 || led_o !== 4'b1000) begin
      bad++; $display("FAIL coincident_after got=%0d/%b want=1/1000", mode_o, led_o);
    end
  endtask

  task automatic test_reset_mid;
    tick_once();
    tick_once();
    total++; if (led_o !== 4'b0010) begin bad++; $display("FAIL pre_reset_led got=%b want=0010", led_o); end
    btn_i = 1'b1;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if (led_o !== 4'b0001 || mode_o !== 2'd0) begin
      bad++; $display("FAIL async_reset got=%b/%0d want=0001/0", led_o, mode_o);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    btn_i = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (mode_o !== 2'd0 || led_o !== 4'b0001) begin
      bad++; $display("FAIL debounce_discarded got=%0d/%b want=0/0001", mode_o, led_o);
    end
    hold_button(20, 20);
    total++; if (mode_o !== 2'd1 || led_o !== 4'b1000) begin
      bad++; $display("FAIL press_after_reset got=%0d/%b want=1/1000", mode_o, led_o);
    end
  endtask

  initial begin
    test_reset();
    test_rot_left();
    test_press_latency();
    test_glitch();
    test_bounce();
    test_blink();
    test_coincident();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
